rr_arb_mux: RTL and testbench

Registered N-to-1 round-robin arbitrating multiplexer with valid/ready handshakes on every input channel and on the output. It is the sequential, parametrised successor to the combinational select muxes. The select is generated internally by a fair arbiter instead of being driven externally. It sits where several producers (PE result lanes, DMA channels) share one downstream consumer and need back-pressure and starvation-free access.

---
 rtl/rr_arb_mux_if.sv | 27 ++
 rtl/rr_arb_mux.sv | 88 ++++++++
 tb/tb_rr_arb_mux.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for the round-robin arbitrating mux: N valid/ready input lanes and one output lane.
interface rr_arb_mux_if #(
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned SEL_W = $clog2(NUM_IN);

   logic                  in_valid [NUM_IN];
   logic [DATA_WIDTH-1:0] in_data  [NUM_IN];
   logic                  in_ready [NUM_IN];
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [SEL_W-1:0]      out_sel;
   logic                  out_ready;

   // Producers and consumer side
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   // Arbiter side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N-to-1 round-robin arbitrating mux with one output register stage.
module rr_arb_mux #(
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   rr_arb_mux_if.slave  bus
);
   localparam int unsigned SEL_W = $clog2(NUM_IN);
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_IN - 1);

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0]      out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]      last_grant_q, last_grant_d;

   logic                  load_en_c;
   logic                  grant_vld_c;
   logic [SEL_W-1:0]      grant_c;

   // Channel index base+k modulo NUM_IN; base < NUM_IN and k <= NUM_IN so one wrap suffices.
   function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_IN) s = s - NUM_IN;
      return SEL_W'(s);
   endfunction

   // Output register can take a word when empty or draining this cycle.
   always_comb load_en_c = !out_valid_q || bus.out_ready;

   // Pick the first requesting channel after last_grant in wrap order.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_c     = '0;
      if (load_en_c && !rst) begin
         for (int unsigned k = 1; k <= NUM_IN; k++) begin
            if (!grant_vld_c && bus.in_valid[wrap_add(last_grant_q, k)]) begin
               grant_vld_c = 1'b1;
               grant_c     = wrap_add(last_grant_q, k);
            end
         end
      end
   end

   // One-hot ready back to the granted producer only.
   for (genvar i = 0; i < NUM_IN; i++) begin : g_ready
      assign bus.in_ready[i] = grant_vld_c && (grant_c == SEL_W'(i));
   end

   // Next-state for the output stage and the arbiter pointer.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      last_grant_d = last_grant_q;
      if (load_en_c) begin
         if (grant_vld_c) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.in_data[grant_c];
            out_sel_d    = grant_c;
            last_grant_d = grant_c;
         end else begin
            out_valid_d  = 1'b0;
         end
      end
   end

   // State registers; reset discards any held word and gives channel 0 first priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sel_q    <= '0;
         last_grant_q <= LAST_RST;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sel_q    <= out_sel_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized traffic against a reference model.
module tb_rr_arb_mux;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rr_arb_mux_if #(.NUM_IN(N), .DATA_WIDTH(W)) bus ();
   rr_arb_mux #(.NUM_IN(N), .DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: one output slot plus the index of the last channel served.
   bit         m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   int         m_sel   = 0;
   int         m_last  = N - 1;

   // Channel that should be served this cycle, or -1.
   function automatic int model_grant();
      if (rst) return -1;
      if (m_valid && !bus.out_ready) return -1;
      for (int k = 1; k <= N; k++) begin
         if (bus.in_valid[(m_last + k) % N]) return (m_last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = model_grant();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [N-1:0] dut_ready();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = bus.in_ready[i];
      return r;
   endfunction

   // Advance one clock, updating the model with what the edge should do; returns #1 after the edge.
   task automatic tick();
      int g;
      bit le;
      logic [7:0] gd;
      g  = model_grant();
      le = !m_valid || bus.out_ready;
      gd = (g >= 0) ? bus.in_data[g] : 8'h00;
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_last = N - 1;
      end else if (le) begin
         if (g >= 0) begin
            m_valid = 1'b1; m_data = gd; m_sel = g; m_last = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drive_idle();
      for (int i = 0; i < N; i++) begin
         bus.in_valid[i] = 1'b0;
         bus.in_data[i]  = 8'h00;
      end
   endtask

   task automatic do_reset();
      drive_idle();
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         bus.in_valid[i] = 1'b1;
         bus.in_data[i]  = 8'(8'hA0 + i);
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++;
         if (dut_ready() !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready cyc%0d: got %b want 0000", c, dut_ready());
         end
         tick();
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 2'd0) begin
         n_err++; $display("FAIL reset_out: got v=%b d=%h s=%0d want 0/00/0", bus.out_valid, bus.out_data, bus.out_sel);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (dut_ready() !== 4'b0001) begin
         n_err++; $display("FAIL reset_first_grant: got %b want 0001", dut_ready());
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'hA0) begin
         n_err++; $display("FAIL reset_first_word: got v=%b s=%0d d=%h want 1/0/a0", bus.out_valid, bus.out_sel, bus.out_data);
      end
   endtask

   task automatic test_rotation();
      do_reset();
      for (int i = 0; i < N; i++) begin
         bus.in_valid[i] = 1'b1;
         bus.in_data[i]  = 8'(8'hA0 + i);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k % 4) || bus.out_data !== 8'(8'hA0 + (k % 4))) begin
            n_err++; $display("FAIL rotation[%0d]: got v=%b s=%0d d=%h want 1/%0d/%h", k, bus.out_valid, bus.out_sel, bus.out_data, k % 4, 8'(8'hA0 + (k % 4)));
         end
      end
   endtask

   task automatic test_sparse();
      int exp_seq [4] = '{3, 1, 3, 1};
      do_reset();
      bus.in_valid[1] = 1'b1; bus.in_data[1] = 8'h21;
      bus.in_valid[3] = 1'b1; bus.in_data[3] = 8'h23;
      tick();
      n_cmp++;
      if (bus.out_sel !== 2'd1) begin
         n_err++; $display("FAIL sparse_first: got s=%0d want 1", bus.out_sel);
      end
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++;
         if (bus.in_ready[0] !== 1'b0 || bus.in_ready[2] !== 1'b0) begin
            n_err++; $display("FAIL sparse_idle_ready[%0d]: got %b want 0 on ch0/ch2", k, dut_ready());
         end
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(exp_seq[k])) begin
            n_err++; $display("FAIL sparse[%0d]: got v=%b s=%0d want 1/%0d", k, bus.out_valid, bus.out_sel, exp_seq[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.in_valid[2] = 1'b1; bus.in_data[2] = 8'h5C;
      tick();
      bus.in_valid[2] = 1'b0;
      bus.in_valid[0] = 1'b1; bus.in_data[0] = 8'h30;
      bus.in_valid[1] = 1'b1; bus.in_data[1] = 8'h31;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if (dut_ready() !== 4'b0000) begin
            n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, dut_ready());
         end
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C || bus.out_sel !== 2'd2) begin
            n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want 1/5c/2", c, bus.out_valid, bus.out_data, bus.out_sel);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (dut_ready() !== 4'b0001) begin
         n_err++; $display("FAIL bp_release_ready: got %b want 0001", dut_ready());
      end
      tick();
      n_cmp++;
      if (bus.out_sel !== 2'd0 || bus.out_data !== 8'h30) begin
         n_err++; $display("FAIL bp_release_word: got s=%0d d=%h want 0/30", bus.out_sel, bus.out_data);
      end
   endtask

   task automatic test_idle_gap();
      do_reset();
      bus.in_valid[1] = 1'b1; bus.in_data[1] = 8'h11;
      tick();
      drive_idle();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_sel !== 2'd1) begin
         n_err++; $display("FAIL idle_word: got v=%b d=%h s=%0d want 1/11/1", bus.out_valid, bus.out_data, bus.out_sel);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_empty[%0d]: got v=%b want 0", c, bus.out_valid);
         end
      end
      bus.in_valid[0] = 1'b1; bus.in_data[0] = 8'h40;
      bus.in_valid[1] = 1'b1; bus.in_data[1] = 8'h41;
      #1;
      n_cmp++;
      if (dut_ready() !== 4'b0001) begin
         n_err++; $display("FAIL idle_resume_ready: got %b want 0001", dut_ready());
      end
      tick();
      n_cmp++;
      if (bus.out_sel !== 2'd0 || bus.out_data !== 8'h40) begin
         n_err++; $display("FAIL idle_resume_word: got s=%0d d=%h want 0/40", bus.out_sel, bus.out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_valid[0] = 1'b1; bus.in_data[0] = 8'h77;
      tick();
      drive_idle();
      bus.out_ready = 1'b0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77) begin
         n_err++; $display("FAIL rmid_hold: got v=%b d=%h want 1/77", bus.out_valid, bus.out_data);
      end
      bus.in_valid[0] = 1'b1; bus.in_data[0] = 8'h50;
      bus.in_valid[1] = 1'b1; bus.in_data[1] = 8'h51;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (dut_ready() !== 4'b0000) begin
         n_err++; $display("FAIL rmid_ready_in_rst: got %b want 0000", dut_ready());
      end
      tick();
      rst = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++; $display("FAIL rmid_discard: got v=%b want 0", bus.out_valid);
      end
      #1;
      n_cmp++;
      if (dut_ready() !== 4'b0001) begin
         n_err++; $display("FAIL rmid_restart_ready: got %b want 0001", dut_ready());
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 8'h50) begin
         n_err++; $display("FAIL rmid_restart_word: got v=%b s=%0d d=%h want 1/0/50", bus.out_valid, bus.out_sel, bus.out_data);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      int wait_cnt [N];
      int max_wait = 0;
      bit xfer;
      do_reset();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!bus.in_valid[i] && ($urandom_range(0, 1) == 1)) begin
               bus.in_valid[i] = 1'b1;
               bus.in_data[i]  = 8'($urandom);
            end
         end
         bus.out_ready = ($urandom_range(0, 9) < 7);
         #1;
         r = dut_ready();
         n_cmp++;
         if (r !== model_ready()) begin
            n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, r, model_ready());
         end
         xfer = (model_ready() != '0);
         for (int i = 0; i < N; i++) begin
            if (xfer && bus.in_valid[i]) begin
               if (model_ready()[i]) wait_cnt[i] = 0;
               else begin
                  wait_cnt[i]++;
                  if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
               end
            end
         end
         tick();
         for (int i = 0; i < N; i++) if (r[i]) bus.in_valid[i] = 1'b0;
         n_cmp++;
         if (bus.out_valid !== m_valid || (m_valid && (bus.out_data !== m_data || bus.out_sel !== 2'(m_sel)))) begin
            n_err++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want %b/%h/%0d", c, bus.out_valid, bus.out_data, bus.out_sel, m_valid, m_data, m_sel);
         end
      end
      n_cmp++;
      if (max_wait > N - 1) begin
         n_err++; $display("FAIL rand_fairness: got max wait %0d transfers want <= %0d", max_wait, N - 1);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      drive_idle();
      test_reset();
      test_rotation();
      test_sparse();
      test_backpressure();
      test_idle_gap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
